// File: rtl/solve_matrix_control.sv
// Sequencer for the Gauss-Jordan solve datapath. It issues one command per stage and
// advances on level acks. It also provides restart, abort, a per-stage watchdog and status.
module solve_matrix_control #(
    parameter int              WD_W     = 16,
    parameter logic [WD_W-1:0] MAX_WAIT = 16'd4000
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       abort,
    input  logic       triangular_reached,
    input  logic       row_updated,
    input  logic       leading_number_found,
    input  logic       double_entries_read,
    input  logic       double_entries_wrote,
    input  logic       rows_swapped,
    input  logic       denominator_fetched,
    input  logic       division_done,
    input  logic       multiply_row_chosen,
    input  logic       multiplier_fetched,
    input  logic       multiplication_done,
    input  logic       type_III_elimination_done,
    output logic       data_reset,
    output logic       go_update_row,
    output logic       find_leading_number,
    output logic       read_double_entries,
    output logic       write_double_entries,
    output logic       go_fetch_denominator,
    output logic       go_input_divider,
    output logic       choose_multiply_row,
    output logic       go_fetch_multiplier,
    output logic       go_input_multiplier,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] state_o,
    output logic [3:0] pivot_count
);

    // state   | meaning
    // IDLE    | waiting for start
    // RST     | one-cycle datapath reset, pivot count cleared
    // UPD     | update row / test for triangular form
    // FIND    | search pivot column for a leading number
    // RD, WR  | swap rows entry by entry
    // FDEN    | fetch pivot denominator
    // DIV     | normalise pivot row
    // CHR     | choose row to eliminate
    // FMUL    | fetch multiplier
    // MUL     | type-III elimination step
    // DONE    | solve complete, start restarts
    // ERROR   | watchdog expired, left only by abort or reset
    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_RST   = 4'd1,
        S_UPD   = 4'd2,
        S_FIND  = 4'd3,
        S_RD    = 4'd4,
        S_WR    = 4'd5,
        S_FDEN  = 4'd6,
        S_DIV   = 4'd7,
        S_CHR   = 4'd8,
        S_FMUL  = 4'd9,
        S_MUL   = 4'd10,
        S_DONE  = 4'd11,
        S_ERROR = 4'd12
    } state_t;

    state_t          state, next_state;
    logic [WD_W-1:0] wd, wd_d, wd_inc;
    logic [3:0]      pivot_q, pivot_d;
    logic [9:0]      cmd_q, cmd_d;
    logic            busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic            cmd_state, timeout;

    assign cmd_state = (state != S_IDLE) && (state != S_DONE) && (state != S_ERROR);
    assign wd_inc    = (&wd) ? wd : wd + 1'b1;
    assign timeout   = (MAX_WAIT != '0) && (wd_inc >= MAX_WAIT);

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = S_RST;
            S_RST:   next_state = S_UPD;
            S_UPD:   if (triangular_reached)        next_state = S_DONE;
                     else if (row_updated)          next_state = S_FIND;
            S_FIND:  if (rows_swapped)              next_state = S_FDEN;
                     else if (leading_number_found) next_state = S_RD;
            S_RD:    if (rows_swapped)              next_state = S_FDEN;
                     else if (double_entries_read)  next_state = S_WR;
            S_WR:    if (double_entries_wrote)      next_state = S_RD;
            S_FDEN:  if (denominator_fetched)       next_state = S_DIV;
            S_DIV:   if (division_done)             next_state = S_CHR;
            S_CHR:   if (type_III_elimination_done) next_state = S_UPD;
                     else if (multiply_row_chosen)  next_state = S_FMUL;
            S_FMUL:  if (multiplier_fetched)        next_state = S_MUL;
            S_MUL:   if (multiplication_done)       next_state = S_CHR;
            S_DONE:  if (start) next_state = S_RST;
            S_ERROR: next_state = S_ERROR;
            default: next_state = S_IDLE;
        endcase
        // A stage that acks on the same edge the watchdog expires is allowed to advance.
        if (cmd_state && (next_state == state) && timeout) next_state = S_ERROR;
        if (abort) next_state = S_IDLE;
    end

    always_comb begin
        wd_d    = (next_state != state) ? '0 : (cmd_state ? wd_inc : wd);
        pivot_d = pivot_q;
        if (next_state == S_RST)
            pivot_d = 4'd0;
        else if ((state == S_CHR) && (next_state == S_UPD) && (pivot_q != 4'hF))
            pivot_d = pivot_q + 4'd1;

        cmd_d = '0;
        case (next_state)
            S_RST:   cmd_d[0] = 1'b1;
            S_UPD:   cmd_d[1] = 1'b1;
            S_FIND:  cmd_d[2] = 1'b1;
            S_RD:    cmd_d[3] = 1'b1;
            S_WR:    cmd_d[4] = 1'b1;
            S_FDEN:  cmd_d[5] = 1'b1;
            S_DIV:   cmd_d[6] = 1'b1;
            S_CHR:   cmd_d[7] = 1'b1;
            S_FMUL:  cmd_d[8] = 1'b1;
            S_MUL:   cmd_d[9] = 1'b1;
            default: cmd_d = '0;
        endcase
        busy_d  = (next_state != S_IDLE) && (next_state != S_DONE) && (next_state != S_ERROR);
        done_d  = (next_state == S_DONE);
        error_d = (next_state == S_ERROR);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= S_IDLE;
            wd      <= '0;
            pivot_q <= 4'd0;
            cmd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state   <= next_state;
            wd      <= wd_d;
            pivot_q <= pivot_d;
            cmd_q   <= cmd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign data_reset           = cmd_q[0];
    assign go_update_row        = cmd_q[1];
    assign find_leading_number  = cmd_q[2];
    assign read_double_entries  = cmd_q[3];
    assign write_double_entries = cmd_q[4];
    assign go_fetch_denominator = cmd_q[5];
    assign go_input_divider     = cmd_q[6];
    assign choose_multiply_row  = cmd_q[7];
    assign go_fetch_multiplier  = cmd_q[8];
    assign go_input_multiplier  = cmd_q[9];
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign error                = error_q;
    assign state_o              = state;
    assign pivot_count          = pivot_q;

endmodule

// File: tb/tb_solve_matrix_control.sv
// Directed bench for solve_matrix_control: inputs driven and outputs sampled on the
// falling edge, so the DUT sees stable inputs at every rising edge.
module tb_solve_matrix_control;

    localparam logic [3:0] ST_IDLE = 4'd0,  ST_RST = 4'd1,  ST_UPD = 4'd2,  ST_FIND = 4'd3,
                           ST_RD   = 4'd4,  ST_WR  = 4'd5,  ST_FDEN = 4'd6, ST_DIV = 4'd7,
                           ST_CHR  = 4'd8,  ST_FMUL = 4'd9, ST_MUL = 4'd10, ST_DONE = 4'd11,
                           ST_ERROR = 4'd12;

    // ack bit order: triangular, row_updated, leading, dbl_read, dbl_wrote, swapped,
    // denominator, division, mrow_chosen, mult_fetched, mult_done, type_III
    logic        clk, resetn, start, abort;
    logic [11:0] ack;
    logic        data_reset, go_update_row, find_leading_number, read_double_entries;
    logic        write_double_entries, go_fetch_denominator, go_input_divider;
    logic        choose_multiply_row, go_fetch_multiplier, go_input_multiplier;
    logic        busy, done, error;
    logic [3:0]  state_o, pivot_count;
    logic [9:0]  cmd;

    int n_tests = 0;
    int n_fail  = 0;
    int onehot_err = 0;

    solve_matrix_control #(.WD_W(16), .MAX_WAIT(16'd20)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .triangular_reached(ack[0]), .row_updated(ack[1]), .leading_number_found(ack[2]),
        .double_entries_read(ack[3]), .double_entries_wrote(ack[4]), .rows_swapped(ack[5]),
        .denominator_fetched(ack[6]), .division_done(ack[7]), .multiply_row_chosen(ack[8]),
        .multiplier_fetched(ack[9]), .multiplication_done(ack[10]),
        .type_III_elimination_done(ack[11]),
        .data_reset(data_reset), .go_update_row(go_update_row),
        .find_leading_number(find_leading_number), .read_double_entries(read_double_entries),
        .write_double_entries(write_double_entries), .go_fetch_denominator(go_fetch_denominator),
        .go_input_divider(go_input_divider), .choose_multiply_row(choose_multiply_row),
        .go_fetch_multiplier(go_fetch_multiplier), .go_input_multiplier(go_input_multiplier),
        .busy(busy), .done(done), .error(error), .state_o(state_o), .pivot_count(pivot_count)
    );

    assign cmd = {go_input_multiplier, go_fetch_multiplier, choose_multiply_row, go_input_divider,
                  go_fetch_denominator, write_double_entries, read_double_entries,
                  find_leading_number, go_update_row, data_reset};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if ($countones(cmd) > 1) onehot_err++;

    initial begin
        #100000;
        $display("FAIL global_timeout state=%0d", state_o);
        $fatal(1, "timeout");
    end

    function automatic logic [9:0] exp_cmd(input logic [3:0] st);
        logic [9:0] c;
        c = '0;
        case (st)
            ST_RST:  c[0] = 1'b1;
            ST_UPD:  c[1] = 1'b1;
            ST_FIND: c[2] = 1'b1;
            ST_RD:   c[3] = 1'b1;
            ST_WR:   c[4] = 1'b1;
            ST_FDEN: c[5] = 1'b1;
            ST_DIV:  c[6] = 1'b1;
            ST_CHR:  c[7] = 1'b1;
            ST_FMUL: c[8] = 1'b1;
            ST_MUL:  c[9] = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Datapath responder: ack arrives 3 cycles after the command was first seen.
    task automatic ack_after3(input int idx);
        repeat (2) @(negedge clk);
        ack[idx] = 1'b1;
        @(negedge clk);
        ack[idx] = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; start = 1'b0; abort = 1'b0; ack = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({cmd, busy, done, error, state_o, pivot_count} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=0", {cmd, busy, done, error, state_o, pivot_count});
        end
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if (state_o !== ST_IDLE || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle state=%0d busy=%b want state=0 busy=0", state_o, busy);
        end
    endtask

    task automatic test_start_abort_idle();
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        n_tests++;
        if (state_o !== ST_IDLE || cmd !== 10'd0) begin
            n_fail++;
            $display("FAIL start_abort_idle state=%0d cmd=%b want state=0 cmd=0", state_o, cmd);
        end
    endtask

    task automatic test_full_solve();
        logic [3:0] st[18] = '{ST_RST, ST_UPD, ST_FIND, ST_FDEN, ST_DIV, ST_CHR, ST_FMUL, ST_MUL,
                               ST_CHR, ST_UPD, ST_FIND, ST_FDEN, ST_DIV, ST_CHR, ST_FMUL, ST_MUL,
                               ST_CHR, ST_UPD};
        int         ak[18] = '{-1, 1, 5, 6, 7, 8, 9, 10, 11, 1, 5, 6, 7, 8, 9, 10, 11, 0};
        pulse_start();
        for (int i = 0; i < 18; i++) begin
            n_tests++;
            if (state_o !== st[i] || cmd !== exp_cmd(st[i])) begin
                n_fail++;
                $display("FAIL solve_step%0d state=%0d cmd=%b want state=%0d cmd=%b",
                         i, state_o, cmd, st[i], exp_cmd(st[i]));
            end
            if (ak[i] < 0) @(negedge clk);
            else ack_after3(ak[i]);
        end
        n_tests++;
        if (state_o !== ST_DONE || done !== 1'b1 || busy !== 1'b0 || pivot_count !== 4'd2
            || cmd !== 10'd0) begin
            n_fail++;
            $display("FAIL solve_done state=%0d done=%b busy=%b pivots=%0d cmd=%b want 11/1/0/2/0",
                     state_o, done, busy, pivot_count, cmd);
        end
        n_tests++;
        if (onehot_err !== 0) begin
            n_fail++;
            $display("FAIL solve_onehot violations=%0d want 0", onehot_err);
        end
    endtask

    task automatic test_restart_swap();
        logic [3:0] st[8] = '{ST_UPD, ST_FIND, ST_RD, ST_WR, ST_RD, ST_WR, ST_RD, ST_WR};
        int         ak[8] = '{1, 2, 3, 4, 3, 4, 3, 4};
        pulse_start();
        n_tests++;
        if (state_o !== ST_RST || cmd !== 10'b1 || pivot_count !== 4'd0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_rst state=%0d cmd=%b pivots=%0d done=%b want 1/0000000001/0/0",
                     state_o, cmd, pivot_count, done);
        end
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (state_o !== st[i] || cmd !== exp_cmd(st[i])) begin
                n_fail++;
                $display("FAIL swap_step%0d state=%0d cmd=%b want state=%0d cmd=%b",
                         i, state_o, cmd, st[i], exp_cmd(st[i]));
            end
            ack_after3(ak[i]);
        end
        ack[4] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if (state_o !== ST_RD) begin
                n_fail++;
                $display("FAIL stale_wrote_%0d state=%0d want %0d", i, state_o, ST_RD);
            end
        end
        ack[4] = 1'b0; ack[5] = 1'b1;
        @(negedge clk);
        ack[5] = 1'b0;
        n_tests++;
        if (state_o !== ST_FDEN || cmd !== exp_cmd(ST_FDEN)) begin
            n_fail++;
            $display("FAIL swap_to_fden state=%0d cmd=%b want %0d", state_o, cmd, ST_FDEN);
        end
    endtask

    task automatic test_abort_mul();
        int seq[9] = '{6, 7, 11, 1, 5, 6, 7, 8, 9};
        for (int i = 0; i < 9; i++) ack_after3(seq[i]);
        n_tests++;
        if (state_o !== ST_MUL || go_input_multiplier !== 1'b1 || pivot_count !== 4'd1) begin
            n_fail++;
            $display("FAIL reach_mul state=%0d gim=%b pivots=%0d want 10/1/1",
                     state_o, go_input_multiplier, pivot_count);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_tests++;
        if (state_o !== ST_IDLE || go_input_multiplier !== 1'b0 || cmd !== 10'd0
            || pivot_count !== 4'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_mul state=%0d cmd=%b pivots=%0d busy=%b want 0/0/1/0",
                     state_o, cmd, pivot_count, busy);
        end
        pulse_start();
        n_tests++;
        if (state_o !== ST_RST || cmd !== 10'b1) begin
            n_fail++;
            $display("FAIL abort_restart_rst state=%0d cmd=%b want 1/0000000001", state_o, cmd);
        end
        @(negedge clk);
        n_tests++;
        if (state_o !== ST_UPD || cmd !== 10'b10) begin
            n_fail++;
            $display("FAIL abort_restart_upd state=%0d cmd=%b want 2/0000000010", state_o, cmd);
        end
    endtask

    task automatic test_watchdog();
        ack_after3(1);
        n_tests++;
        if (state_o !== ST_FIND) begin
            n_fail++;
            $display("FAIL wd_enter_find state=%0d want %0d", state_o, ST_FIND);
        end
        repeat (19) @(negedge clk);
        n_tests++;
        if (state_o !== ST_FIND || error !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_early state=%0d error=%b want 3/0", state_o, error);
        end
        @(negedge clk);
        n_tests++;
        if (state_o !== ST_ERROR || error !== 1'b1 || cmd !== 10'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_expire state=%0d error=%b cmd=%b busy=%b want 12/1/0/0",
                     state_o, error, cmd, busy);
        end
        start = 1'b1; ack = '1;
        repeat (3) @(negedge clk);
        start = 1'b0; ack = '0;
        n_tests++;
        if (state_o !== ST_ERROR || error !== 1'b1) begin
            n_fail++;
            $display("FAIL error_sticky state=%0d error=%b want 12/1", state_o, error);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_tests++;
        if (state_o !== ST_IDLE || error !== 1'b0) begin
            n_fail++;
            $display("FAIL error_abort state=%0d error=%b want 0/0", state_o, error);
        end
    endtask

    task automatic test_async_reset_div();
        pulse_start();
        @(negedge clk);
        ack_after3(1);
        ack_after3(5);
        ack_after3(6);
        n_tests++;
        if (state_o !== ST_DIV || go_input_divider !== 1'b1) begin
            n_fail++;
            $display("FAIL reach_div state=%0d gid=%b want 7/1", state_o, go_input_divider);
        end
        #2;
        resetn = 1'b0;
        #1;
        n_tests++;
        if ({cmd, busy, done, error, state_o, pivot_count} !== 21'd0) begin
            n_fail++;
            $display("FAIL async_reset got=%h want=0", {cmd, busy, done, error, state_o, pivot_count});
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        n_tests++;
        if (state_o !== ST_IDLE || busy !== 1'b0 || cmd !== 10'd0) begin
            n_fail++;
            $display("FAIL post_reset state=%0d busy=%b cmd=%b want 0/0/0", state_o, busy, cmd);
        end
        n_tests++;
        if (onehot_err !== 0) begin
            n_fail++;
            $display("FAIL final_onehot violations=%0d want 0", onehot_err);
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; abort = 1'b0; ack = '0;
        @(negedge clk);
        test_reset();
        test_start_abort_idle();
        test_full_solve();
        test_restart_swap();
        test_abort_mul();
        test_watchdog();
        test_async_reset_div();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/solve_matrix_control.md
Name: solve_matrix_control

Overview:
- FSM that drives the go/handshake inputs of the Gauss-Jordan matrix datapath (row update, pivot search, row swap, normalisation divide, type-III elimination) and advances on its level acknowledges.
- Sits between the top-level start/done interface and the datapath. Adds a restart path, an abort path, a per-stage watchdog and status outputs.

Parameters:
- WD_W, 16, width of the watchdog cycle counter.
- MAX_WAIT, 16'd4000, maximum number of cycles in any wait state before entering ERROR. A value of 0 disables the watchdog.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  begin a solve; sampled only in IDLE and DONE.
- abort  in  1  synchronous abort; returns the FSM to IDLE from any state.
- triangular_reached, row_updated, leading_number_found, double_entries_read, double_entries_wrote, rows_swapped  in  1 each  datapath acks.
- denominator_fetched, division_done, multiply_row_chosen, multiplier_fetched, multiplication_done, type_III_elimination_done  in  1 each  datapath acks.
- data_reset, go_update_row, find_leading_number, read_double_entries, write_double_entries  out  1 each  datapath commands.
- go_fetch_denominator, go_input_divider, choose_multiply_row, go_fetch_multiplier, go_input_multiplier  out  1 each  datapath commands.
- busy  out  1  high in every state except IDLE, DONE and ERROR.
- done  out  1  high while in DONE.
- error  out  1  high while in ERROR.
- state_o  out  4  current state encoding, for debug.
- pivot_count  out  4  number of pivot rows completed in the current solve.

Behaviour:
- All outputs are registered Moore outputs.
- Exactly one command output is high in each command state. All command outputs are 0 in IDLE, DONE and ERROR (one-hot-or-zero).
- Reset (resetn=0, asynchronous): state=IDLE; all commands, busy, done and error = 0; pivot_count=0; watchdog=0.
- Acks are levels. Each state samples only its own exit acks, so a stale ack from an earlier stage is ignored.
- When an ack is seen, the state changes on that edge; the command drops and the next command rises in the following cycle.
- State sequence (state : command asserted : exit condition -> next state):
  - IDLE : none : start=1 -> RST.
  - RST : data_reset for exactly 1 cycle : unconditional -> UPD; pivot_count cleared. data_reset is never high in the same cycle as any other command.
  - UPD : go_update_row : triangular_reached -> DONE; else row_updated -> FIND.
  - FIND : find_leading_number : rows_swapped -> FDEN; else leading_number_found -> RD. rows_swapped has priority.
  - RD : read_double_entries : rows_swapped -> FDEN; else double_entries_read -> WR. rows_swapped has priority.
  - WR : write_double_entries : double_entries_wrote -> RD.
  - FDEN : go_fetch_denominator : denominator_fetched -> DIV.
  - DIV : go_input_divider : division_done -> CHR.
  - CHR : choose_multiply_row : type_III_elimination_done -> UPD with pivot_count+1; else multiply_row_chosen -> FMUL. type_III_elimination_done has priority.
  - FMUL : go_fetch_multiplier : multiplier_fetched -> MUL.
  - MUL : go_input_multiplier : multiplication_done -> CHR.
  - DONE : none : start=1 -> RST (restart without reset).
  - ERROR : none : left only via abort or resetn.
- Watchdog:
  - Cleared on every state change; increments each cycle spent in a command state.
  - When it reaches MAX_WAIT (with MAX_WAIT≠0) -> ERROR. This catches a singular pivot column, where the datapath never acks FIND.
  - The counter saturates and does not wrap.
- abort=1 -> IDLE on the next edge from any state. Commands drop that edge; pivot_count is held. abort has priority over acks and over the watchdog.
- Simultaneous start and abort in IDLE: abort wins and the FSM stays in IDLE.
- pivot_count saturates at 15.

Test Plan:
- Responder model acks each command after 3 cycles, dimension=2, pivot always on the diagonal -> command order RST, UPD, FIND, FDEN, DIV, CHR, FMUL, MUL, CHR, UPD, repeated for row 1, then UPD→DONE. Required: done=1, pivot_count=2, and no two commands ever high in the same cycle.
- Pivot on row 0 of dimension 2 needs a swap; model acks leading_number_found, then double_entries_read/double_entries_wrote 3 times, then rows_swapped -> FSM visits RD/WR 3 times, then FDEN. A stale double_entries_wrote held high while in RD must cause no transition.
- Model never acks find_leading_number, MAX_WAIT=20 -> error=1 exactly 20 cycles after FIND is entered. All commands are 0. abort returns the FSM to IDLE with error=0.
- abort pulsed while in MUL -> go_input_multiplier=0 and state_o=IDLE on the next edge. A subsequent start issues a 1-cycle data_reset before go_update_row.
- resetn driven low mid-DIV for 2 cycles, asynchronously -> all outputs 0 immediately, before the next clock edge, and state=IDLE.
- From DONE, start=1 -> data_reset pulses for 1 cycle and pivot_count clears to 0.
